// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter feeding bytes to a single UART transmitter,
// with multi-byte ownership locking and a sticky transmit-timeout flag.
module uart_tx_arbiter #(
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic        Clock_100MHz,
   input  logic        Reset_n,
   input  logic [3:0]  Req,
   input  logic [31:0] Req_Data,
   input  logic [3:0]  Req_Lock,
   output logic [3:0]  Ack,
   output logic        TX_Start,
   output logic [7:0]  TX_Data,
   input  logic        TX_Busy,
   input  logic        TX_Done,
   output logic [1:0]  Owner,
   output logic        Arb_Busy,
   output logic        Error
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

   state_t        state;
   logic          lock_hold;
   logic [CW-1:0] timeout_count;
   logic [1:0]    winner;
   logic [1:0]    cand1, cand2, cand3;

   // Owner doubles as the round-robin pointer: both always hold the last winner.
   assign cand1 = Owner + 2'd1;
   assign cand2 = Owner + 2'd2;
   assign cand3 = Owner + 2'd3;

   always_comb begin
      winner = Owner;
      if (lock_hold && Req[Owner])
         winner = Owner;
      else if (Req[cand1])
         winner = cand1;
      else if (Req[cand2])
         winner = cand2;
      else if (Req[cand3])
         winner = cand3;
      else
         winner = Owner;
   end

   always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= IDLE;
         Ack           <= 4'b0000;
         TX_Start      <= 1'b0;
         TX_Data       <= 8'h00;
         Owner         <= 2'd3;
         lock_hold     <= 1'b0;
         timeout_count <= '0;
         Error         <= 1'b0;
         Arb_Busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((Req != 4'b0000) && !TX_Busy) begin
                  Owner     <= winner;
                  TX_Data   <= Req_Data[{winner, 3'b000} +: 8];
                  lock_hold <= Req_Lock[winner];
                  Ack       <= 4'b0001 << winner;
                  TX_Start  <= 1'b1;
                  Arb_Busy  <= 1'b1;
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               Ack           <= 4'b0000;
               TX_Start      <= 1'b0;
               timeout_count <= '0;
               state         <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // A completing frame takes priority over a timeout in the same cycle.
               if (TX_Done) begin
                  timeout_count <= '0;
                  Arb_Busy      <= 1'b0;
                  state         <= IDLE;
               end else if (timeout_count == LAST_COUNT) begin
                  Error         <= 1'b1;
                  lock_hold     <= 1'b0;
                  timeout_count <= '0;
                  Arb_Busy      <= 1'b0;
                  state         <= IDLE;
               end else begin
                  timeout_count <= timeout_count + 1'b1;
               end
            end
            default: begin
               Ack      <= 4'b0000;
               TX_Start <= 1'b0;
               Arb_Busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_uart_tx_arbiter;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req, req_lock, ack;
   logic [31:0] req_data;
   logic        tx_busy, tx_done, tx_start, arb_busy, error;
   logic [7:0]  tx_data;
   logic [1:0]  owner;

   int tests_run = 0;
   int tests_failed = 0;

   // Model: m_since = -1 when no frame is in flight, otherwise cycles since TX_Start.
   int          m_since;
   int          m_owner;
   bit          m_lock;
   bit          m_error;
   logic [7:0]  m_data;
   logic [3:0]  m_ack;
   bit          m_start;

   logic [3:0]  obs_ack, launch_ack;
   logic [7:0]  obs_data, launch_data;
   logic [1:0]  obs_owner, launch_owner;
   logic        obs_start, obs_busy, obs_error;

   uart_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .Clock_100MHz(clk),
      .Reset_n     (rst_n),
      .Req         (req),
      .Req_Data    (req_data),
      .Req_Lock    (req_lock),
      .Ack         (ack),
      .TX_Start    (tx_start),
      .TX_Data     (tx_data),
      .TX_Busy     (tx_busy),
      .TX_Done     (tx_done),
      .Owner       (owner),
      .Arb_Busy    (arb_busy),
      .Error       (error)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_since = -1;
      m_owner = 3;
      m_lock  = 1'b0;
      m_error = 1'b0;
      m_data  = 8'h00;
      m_ack   = 4'b0000;
      m_start = 1'b0;
   endtask

   // Round robin from the last winner, unless a locked owner is still requesting.
   function automatic int pick(input logic [3:0] r);
      if (m_lock && r[m_owner]) return m_owner;
      for (int k = 1; k <= 4; k++)
         if (r[(m_owner + k) % 4]) return (m_owner + k) % 4;
      return m_owner;
   endfunction

   task automatic modelStep(input logic [3:0] r, input logic [31:0] d, input logic [3:0] lk,
                            input logic busy, input logic done);
      int w;
      if (m_since == 0) begin
         m_since = 1;
         m_ack   = 4'b0000;
         m_start = 1'b0;
      end else if (m_since > 0) begin
         if (done) m_since = -1;
         else if (m_since == T) begin
            m_error = 1'b1;
            m_lock  = 1'b0;
            m_since = -1;
         end else m_since++;
      end else if (r != 4'b0000 && !busy) begin
         w       = pick(r);
         m_owner = w;
         m_data  = d[8*w +: 8];
         m_lock  = lk[w];
         m_ack   = 4'b0001 << w;
         m_start = 1'b1;
         m_since = 0;
      end
   endtask

   task automatic checkAll();
      obs_ack   = ack;
      obs_start = tx_start;
      obs_data  = tx_data;
      obs_owner = owner;
      obs_busy  = arb_busy;
      obs_error = error;
      checkOutput("ack",      {28'd0, ack},      {28'd0, m_ack});
      checkOutput("tx_start", {31'd0, tx_start}, {31'd0, m_start});
      checkOutput("tx_data",  {24'd0, tx_data},  {24'd0, m_data});
      checkOutput("owner",    {30'd0, owner},    m_owner);
      checkOutput("arb_busy", {31'd0, arb_busy}, (m_since >= 0) ? 32'd1 : 32'd0);
      checkOutput("error",    {31'd0, error},    {31'd0, m_error});
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic [3:0] lk,
                                input logic busy, input logic done);
      @(negedge clk);
      checkAll();
      req      = r;
      req_data = d;
      req_lock = lk;
      tx_busy  = busy;
      tx_done  = done;
      modelStep(r, d, lk, busy, done);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n    = 1'b0;
      req      = 4'b0000;
      req_data = 32'd0;
      req_lock = 4'b0000;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      modelReset();
      #1;
      checkAll();
      @(negedge clk);
      checkAll();
      rst_n = 1'b1;
   endtask

   // Grant, observe the launch cycle, then return TX_Done 'delay' cycles after TX_Start.
   task automatic runFrame(input logic [3:0] r, input logic [31:0] d, input logic [3:0] lk, input int delay);
      applyStimulus(r, d, lk, 1'b0, 1'b0);
      applyStimulus(r, d, lk, 1'b1, 1'b0);
      launch_ack   = obs_ack;
      launch_data  = obs_data;
      launch_owner = obs_owner;
      for (int i = 1; i < delay; i++) applyStimulus(r, d, lk, 1'b1, 1'b0);
      applyStimulus(r, d, lk, 1'b1, 1'b1);
   endtask

   initial begin
      logic [31:0] d;
      logic [3:0]  rq, lk;
      logic [31:0] dt;
      logic        bz, dn;
      int          cnt;
      logic [1:0]  lock_owner_exp [4];
      logic [3:0]  lock_seq [4];

      rst_n = 1'b0; req = 4'b0000; req_data = 32'd0; req_lock = 4'b0000;
      tx_busy = 1'b0; tx_done = 1'b0;
      modelReset();
      doReset();
      checkOutput("reset_owner",    {30'd0, owner},    32'd3);
      checkOutput("reset_tx_data",  {24'd0, tx_data},  32'd0);
      checkOutput("reset_arb_busy", {31'd0, arb_busy}, 32'd0);

      for (int b = 0; b < 4; b++) begin
         runFrame(4'hF, 32'h44332211, 4'h0, 5);
         checkOutput("rr_ack",  {28'd0, launch_ack},  32'd1 << b);
         checkOutput("rr_data", {24'd0, launch_data}, 32'h11 * (b + 1));
      end

      runFrame(4'b0010, 32'h00005A00, 4'b0010, 3);
      checkOutput("lock_pre_owner", {30'd0, launch_owner}, 32'd1);
      lock_seq = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
      lock_owner_exp = '{2'd1, 2'd1, 2'd1, 2'd3};
      for (int g = 0; g < 4; g++) begin
         runFrame(4'b1010, 32'hC3B2A190, lock_seq[g], 3);
         checkOutput("lock_owner", {30'd0, launch_owner}, {30'd0, lock_owner_exp[g]});
      end

      d = $urandom;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0100, d, 4'b0000, 1'b1, 1'b0);
         checkOutput("busy_block_ack", {28'd0, obs_ack}, 32'd0);
      end
      applyStimulus(4'b0100, d, 4'b0000, 1'b0, 1'b0);
      applyStimulus(4'b0100, d, 4'b0000, 1'b1, 1'b0);
      checkOutput("busy_release_start", {31'd0, obs_start}, 32'd1);
      checkOutput("busy_release_data",  {24'd0, obs_data},  {24'd0, d[23:16]});
      applyStimulus(4'b0000, d, 4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b0000, d, 4'b0000, 1'b1, 1'b1);

      runFrame(4'b0001, d, 4'b0000, T);
      applyStimulus(4'b0000, d, 4'b0000, 1'b0, 1'b0);
      checkOutput("tie_error", {31'd0, obs_error}, 32'd0);
      checkOutput("tie_idle",  {31'd0, obs_busy},  32'd0);

      applyStimulus(4'b1000, d, 4'b0000, 1'b0, 1'b0);
      applyStimulus(4'b0000, d, 4'b0000, 1'b1, 1'b0);
      checkOutput("to_start", {31'd0, obs_start}, 32'd1);
      for (int i = 0; i < T; i++) applyStimulus(4'b0000, d, 4'b0000, 1'b1, 1'b0);
      checkOutput("to_not_yet", {31'd0, obs_error}, 32'd0);
      applyStimulus(4'b0000, d, 4'b0000, 1'b0, 1'b0);
      checkOutput("to_error", {31'd0, obs_error}, 32'd1);
      checkOutput("to_idle",  {31'd0, obs_busy},  32'd0);
      runFrame(4'b0010, d, 4'b0000, 2);
      checkOutput("to_regrant", {28'd0, launch_ack}, 32'b0010);

      applyStimulus(4'b0001, d, 4'b0000, 1'b0, 1'b0);
      applyStimulus(4'b0000, d, 4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, d, 4'b0000, 1'b1, 1'b0);
      doReset();
      applyStimulus(4'b0000, d, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0000, d, 4'b0000, 1'b0, 1'b0);
         checkOutput("rst_abort_ack",   {28'd0, obs_ack},   32'd0);
         checkOutput("rst_abort_start", {31'd0, obs_start}, 32'd0);
      end
      checkOutput("rst_abort_error", {31'd0, obs_error}, 32'd0);
      checkOutput("rst_abort_owner", {30'd0, obs_owner}, 32'd3);

      rq = 4'b0000; dt = 32'd0; cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            doReset();
            rq = 4'b0000;
            cnt = 0;
         end
         for (int i = 0; i < 4; i++) begin
            if (rq[i]) begin
               if (obs_ack[i] || $urandom_range(0, 49) == 0) rq[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               rq[i] = 1'b1;
               dt[8*i +: 8] = 8'($urandom);
            end
         end
         lk = 4'($urandom);
         if (obs_start) cnt = $urandom_range(1, 18);
         if (cnt > 0) begin
            cnt--;
            dn = (cnt == 0);
         end else begin
            dn = ($urandom_range(0, 29) == 0);
         end
         bz = (m_since >= 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
         applyStimulus(rq, dt, lk, bz, dn);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
